fwd_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the MIPS pipeline; successor to the per-stage combinational bypass selectors.
- Keeps its own shadow pipeline of destination records (E, M, W and deeper), filled from decode.
- For each of NUM_RD_PORTS decode-stage source operands it produces:
  - a D-stage forward select (combinational);
  - an E-stage forward select (registered);
  - a global stall.
- Adds load-use / late-result stall detection and a mult/div busy counter, neither of which the combinational selectors provide.

---
 rtl/fwd_scoreboard.sv | 118 +++++++++++
 tb/tb_fwd_scoreboard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: shadow pipeline of destination records behind decode,
// producing D and E bypass selects, load-use/late-result stall and a mult/div busy counter.
module fwd_scoreboard #(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned MD_LATENCY   = 5,
  parameter int unsigned SW           = $clog2(NUM_STAGES),
  parameter int unsigned FW           = $clog2(NUM_STAGES + 2)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic                           id_wr_en,
  input  logic [4:0]                     id_dst,
  input  logic [SW-1:0]                  id_rdy_stage,
  input  logic [5*NUM_RD_PORTS-1:0]      id_src,
  input  logic [NUM_RD_PORTS-1:0]        id_src_en,
  input  logic [NUM_RD_PORTS-1:0]        id_src_use,
  input  logic                           id_md_start,
  input  logic                           id_md_read,
  input  logic                           flush,
  output logic [FW*NUM_RD_PORTS-1:0]     fwd_sel_d,
  output logic [FW*NUM_RD_PORTS-1:0]     fwd_sel_e,
  output logic                           stall,
  output logic                           md_busy
);

  localparam int unsigned CW = $clog2(MD_LATENCY + 1);

  // Slot 0 is E, slot 1 is M, slot 2 is W, deeper slots follow.
  logic [NUM_STAGES-1:0]         slot_vld_q, slot_vld_d;
  logic [NUM_STAGES-1:0]         slot_wr_q, slot_wr_d;
  logic [NUM_STAGES-1:0][4:0]    slot_dst_q, slot_dst_d;
  logic [NUM_STAGES-1:0][SW-1:0] slot_rdy_q, slot_rdy_d;

  logic [FW*NUM_RD_PORTS-1:0]    fwd_sel_e_q, fwd_sel_e_d, sel_e_calc;
  logic [CW-1:0]                 md_cnt_q, md_cnt_d;

  logic                          port_stall, md_stall, ins;
  logic [4:0]                    src;
  logic                          hit;
  int unsigned                   hk, hr;

  always_comb begin
    port_stall = 1'b0;
    fwd_sel_d  = '0;
    sel_e_calc = '0;
    src        = '0;
    hit        = 1'b0;
    hk         = 0;
    hr         = 0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      src = id_src[5*p +: 5];
      hit = 1'b0;
      hk  = 0;
      hr  = 0;
      // Ascending scan keeps the first hit, so the youngest producer wins.
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (!hit && slot_vld_q[k] && slot_wr_q[k] && (slot_dst_q[k] == src) &&
            (src != 5'd0) && id_src_en[p]) begin
          hit = 1'b1;
          hk  = k;
          hr  = 32'(slot_rdy_q[k]);
        end
      end
      if (hit) begin
        if (hk >= hr) fwd_sel_d[FW*p +: FW] = FW'(hk + 32'd1);
        if (!id_src_use[p] && (hk < hr)) port_stall = 1'b1;
        if (id_src_use[p] && (hk + 32'd1 < hr)) port_stall = 1'b1;
        // Producer one slot older when we reach E; past the last slot it has retired.
        if (id_src_use[p] && (hk + 32'd1 < NUM_STAGES)) begin
          sel_e_calc[FW*p +: FW] = FW'(hk + 32'd2);
        end
      end
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = id_valid && (id_md_read || id_md_start) && md_busy;
  assign stall    = id_valid && (port_stall || md_stall);

  assign ins        = id_valid && !stall && !flush && id_wr_en && (id_dst != 5'd0);
  assign slot_vld_d = {slot_vld_q[NUM_STAGES-2:0], ins};
  assign slot_wr_d  = {slot_wr_q[NUM_STAGES-2:0], ins};
  assign slot_dst_d = {slot_dst_q[NUM_STAGES-2:0], id_dst};
  assign slot_rdy_d = {slot_rdy_q[NUM_STAGES-2:0], id_rdy_stage};

  assign fwd_sel_e_d = (stall || flush) ? '0 : sel_e_calc;
  assign fwd_sel_e   = fwd_sel_e_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (id_md_start && id_valid && !stall && !flush) begin
      md_cnt_d = CW'(MD_LATENCY);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      slot_wr_q   <= '0;
      slot_dst_q  <= '0;
      slot_rdy_q  <= '0;
      fwd_sel_e_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_wr_q   <= slot_wr_d;
      slot_dst_q  <= slot_dst_d;
      slot_rdy_q  <= slot_rdy_d;
      fwd_sel_e_q <= fwd_sel_e_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: per-cycle expectations are queued when D inputs are driven
// and popped/compared mid-cycle against the DUT outputs.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_wr_en, id_md_start, id_md_read, flush;
  logic [4:0] id_dst;
  logic [1:0] id_rdy_stage;
  logic [9:0] id_src;
  logic [1:0] id_src_en, id_src_use;
  logic [5:0] fwd_sel_d, fwd_sel_e;
  logic       stall, md_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [5:0] sel_d;
    logic [5:0] sel_e;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  fwd_scoreboard #(
    .NUM_RD_PORTS(2),
    .NUM_STAGES  (3),
    .MD_LATENCY  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_wr_en    (id_wr_en),
    .id_dst      (id_dst),
    .id_rdy_stage(id_rdy_stage),
    .id_src      (id_src),
    .id_src_en   (id_src_en),
    .id_src_use  (id_src_use),
    .id_md_start (id_md_start),
    .id_md_read  (id_md_read),
    .flush       (flush),
    .fwd_sel_d   (fwd_sel_d),
    .fwd_sel_e   (fwd_sel_e),
    .stall       (stall),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_valid = 0; id_wr_en = 0; id_dst = 0; id_rdy_stage = 0; id_src = 0;
    id_src_en = 0; id_src_use = 0; id_md_start = 0; id_md_read = 0; flush = 0;
  endtask

  // Selects are written in octal: 6'oAB means port1=A, port0=B.
  task automatic cyc(input string tag, input logic v, input logic wr, input logic [4:0] dst,
                     input logic [1:0] rdy, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] en, input logic [1:0] us, input logic ms,
                     input logic mr, input logic fl, input logic xs, input logic [5:0] xd,
                     input logic [5:0] xe, input logic xb);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_wr_en = wr; id_dst = dst; id_rdy_stage = rdy; id_src = {s1, s0};
    id_src_en = en; id_src_use = us; id_md_start = ms; id_md_read = mr; flush = fl;
    exp_q.push_back('{tag: tag, stall: xs, sel_d: xd, sel_e: xe, busy: xb});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_stall"}, 32'(stall), 32'(e.stall));
      check({e.tag, "_sel_d"}, 32'(fwd_sel_d), 32'(e.sel_d));
      check({e.tag, "_sel_e"}, 32'(fwd_sel_e), 32'(e.sel_e));
      check({e.tag, "_busy"}, 32'(md_busy), 32'(e.busy));
    end
  endtask

  task automatic idle(input string tag, input logic [5:0] xe);
    cyc(tag, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, xe, 0);
  endtask

  task automatic drain();
    idle("drain", 6'o00); idle("drain", 6'o00); idle("drain", 6'o00);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    #12;
    check("rst_stall", 32'(stall), 0);
    check("rst_sel_d", 32'(fwd_sel_d), 0);
    check("rst_sel_e", 32'(fwd_sel_e), 0);
    check("rst_busy", 32'(md_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU producer forwarded to E from M, then from W, on both ports
    cyc("alu_prod",  1, 1, 5'd3, 2'd1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("alu_use1",  1, 1, 5'd7, 2'd1, 5'd3, 0, 2'b01, 2'b01, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("alu_use2",  1, 0, 5'd0, 2'd0, 5'd7, 5'd3, 2'b11, 2'b11, 0, 0, 0, 0, 6'o20, 6'o02, 0);
    idle("alu_e3", 6'o32);
    drain();

    // load-use: one stall, then W forward in E
    cyc("ld_prod",   1, 1, 5'd4, 2'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("ld_use_st", 1, 1, 5'd8, 2'd1, 5'd4, 0, 2'b01, 2'b01, 0, 0, 0, 1, 6'o00, 6'o00, 0);
    cyc("ld_use_go", 1, 1, 5'd8, 2'd1, 5'd4, 0, 2'b01, 2'b01, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    idle("ld_e3", 6'o03);
    drain();

    // branch compare in D: ALU costs one stall, load costs two
    cyc("br_alu",    1, 1, 5'd5, 2'd1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("br_st",     1, 0, 5'd0, 2'd0, 5'd5, 0, 2'b01, 2'b00, 0, 0, 0, 1, 6'o00, 6'o00, 0);
    cyc("br_fwd_m",  1, 0, 5'd0, 2'd0, 5'd5, 0, 2'b01, 2'b00, 0, 0, 0, 0, 6'o02, 6'o00, 0);
    cyc("br_ld",     1, 1, 5'd5, 2'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("br_ld_st1", 1, 0, 5'd0, 2'd0, 5'd5, 0, 2'b01, 2'b00, 0, 0, 0, 1, 6'o00, 6'o00, 0);
    cyc("br_ld_st2", 1, 0, 5'd0, 2'd0, 5'd5, 0, 2'b01, 2'b00, 0, 0, 0, 1, 6'o00, 6'o00, 0);
    cyc("br_fwd_w",  1, 0, 5'd0, 2'd0, 5'd5, 0, 2'b01, 2'b00, 0, 0, 0, 0, 6'o03, 6'o00, 0);
    drain();

    // youngest of two producers wins; $0 never matches
    cyc("yw_p1",     1, 1, 5'd6, 2'd1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("yw_p2",     1, 1, 5'd6, 2'd1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    idle("yw_gap", 6'o00);
    cyc("yw_use",    1, 0, 5'd0, 2'd0, 5'd0, 5'd6, 2'b11, 2'b00, 0, 0, 0, 0, 6'o20, 6'o00, 0);
    cyc("r0_prod",   1, 1, 5'd0, 2'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("r0_use",    1, 0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b11, 2'b10, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    drain();

    // mult then mfhi: five busy stall cycles
    cyc("md_mult",   1, 0, 5'd0, 2'd0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 6'o00, 6'o00, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("md_mfhi_st", 1, 1, 5'd9, 2'd1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 6'o00, 6'o00, 1);
    end
    cyc("md_mfhi_go", 1, 1, 5'd9, 2'd1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 6'o00, 6'o00, 0);
    drain();

    // reset while stalled with loaded slots and busy counter
    cyc("rs_mult",   1, 0, 5'd0, 2'd0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("rs_ld",     1, 1, 5'd4, 2'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 1);
    cyc("rs_st",     1, 1, 5'd8, 2'd1, 5'd4, 0, 2'b01, 2'b01, 0, 0, 0, 1, 6'o00, 6'o00, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_mid_stall", 32'(stall), 0);
    check("rs_mid_sel_d", 32'(fwd_sel_d), 0);
    check("rs_mid_sel_e", 32'(fwd_sel_e), 0);
    check("rs_mid_busy", 32'(md_busy), 0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rs_after",  1, 1, 5'd8, 2'd1, 5'd4, 0, 2'b01, 2'b01, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    drain();

    // flush: no insertion, E select forced to zero
    cyc("fl_prod",   1, 1, 5'd3, 2'd1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("fl_sq",     1, 1, 5'd10, 2'd1, 5'd3, 0, 2'b01, 2'b01, 0, 0, 1, 0, 6'o00, 6'o00, 0);
    cyc("fl_after",  1, 0, 5'd0, 2'd0, 5'd10, 5'd3, 2'b11, 2'b00, 0, 0, 0, 0, 6'o20, 6'o00, 0);
    drain();
    cyc("fl_ld",     1, 1, 5'd4, 2'd2, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    cyc("fl_ld_st",  1, 1, 5'd8, 2'd1, 5'd4, 0, 2'b01, 2'b01, 0, 0, 1, 1, 6'o00, 6'o00, 0);
    cyc("fl_ld_nx",  1, 0, 5'd0, 2'd0, 5'd8, 5'd4, 2'b11, 2'b10, 0, 0, 0, 0, 6'o00, 6'o00, 0);
    idle("fl_ld_e3", 6'o30);
    drain();
    cyc("fl_mult",   1, 0, 5'd0, 2'd0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 6'o00, 6'o00, 0);
    cyc("fl_mfhi",   1, 1, 5'd9, 2'd1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 6'o00, 6'o00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
